// File: rtl/down_counter_timer_pkg.sv
// Shared types and default widths for the falling-edge down-counter/timer.
package down_counter_timer_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 64;
    localparam int DEFAULT_WRAP_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } timer_state_t;

    function automatic logic is_busy(input timer_state_t s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/down_counter_timer_ctrl.sv
// Timer FSM: decodes commands by priority and issues count/reload strobes to the datapath.
module down_counter_timer_ctrl
    import down_counter_timer_pkg::*;
(
    input  logic clock0,
    input  logic reset_n,
    input  logic load,
    input  logic start,
    input  logic stop,
    input  logic pause,
    input  logic auto_reload,
    input  logic input_zero,
    input  logic count_zero,
    input  logic count_one,
    input  logic reload_zero,
    output logic ld_strobe,
    output logic dec_strobe,
    output logic reload_strobe,
    output logic busy,
    output logic done,
    output logic tc_pulse
);

    timer_state_t state;
    timer_state_t next_state;
    logic         next_tc;

    // Priority is load > stop > start > pause > decrement; reset is applied in the flop block.
    always_comb begin
        next_state    = state;
        next_tc       = 1'b0;
        ld_strobe     = 1'b0;
        dec_strobe    = 1'b0;
        reload_strobe = 1'b0;

        if (load) begin
            ld_strobe = 1'b1;
            if (start) begin
                next_state = input_zero ? DONE : RUN;
                next_tc    = input_zero;
            end else begin
                next_state = IDLE;
            end
        end else if (stop) begin
            next_state = IDLE;
        end else if (start && (state == IDLE || state == DONE)) begin
            next_state = count_zero ? DONE : RUN;
            next_tc    = count_zero;
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        next_state = HOLD;
                    end else if (count_zero) begin
                        // Unreachable in normal operation; parks safely without underflowing.
                        next_state = DONE;
                    end else if (count_one) begin
                        next_tc = 1'b1;
                        if (auto_reload && !reload_zero) begin
                            reload_strobe = 1'b1;
                        end else begin
                            dec_strobe = 1'b1;
                            next_state = DONE;
                        end
                    end else begin
                        dec_strobe = 1'b1;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        next_state = RUN;
                    end
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

    always_ff @(negedge clock0) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= is_busy(next_state);
            done     <= (next_state == DONE);
            tc_pulse <= next_tc;
        end
    end

endmodule

// File: rtl/down_counter_timer_neg.sv
// Loadable down-counter/timer with optional auto-reload; every flop updates on the falling edge of clock0.
module down_counter_timer_neg
    import down_counter_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WRAP_WIDTH    = DEFAULT_WRAP_WIDTH
) (
    input  logic                     clock0,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] counter_input,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     auto_reload,
    output logic [COUNTER_WIDTH-1:0] counter_output,
    output logic                     busy,
    output logic                     done,
    output logic                     tc_pulse,
    output logic [WRAP_WIDTH-1:0]    wrap_count
);

    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] reload;
    logic                     ld_strobe;
    logic                     dec_strobe;
    logic                     reload_strobe;

    down_counter_timer_ctrl u_ctrl (
        .clock0        (clock0),
        .reset_n       (reset_n),
        .load          (load),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .auto_reload   (auto_reload),
        .input_zero    (counter_input == '0),
        .count_zero    (count == '0),
        .count_one     (count == COUNTER_WIDTH'(1)),
        .reload_zero   (reload == '0),
        .ld_strobe     (ld_strobe),
        .dec_strobe    (dec_strobe),
        .reload_strobe (reload_strobe),
        .busy          (busy),
        .done          (done),
        .tc_pulse      (tc_pulse)
    );

    // The wrap counter sticks at all-ones so long periodic runs never alias back to small values.
    always_ff @(negedge clock0) begin
        if (!reset_n) begin
            count      <= '0;
            reload     <= '0;
            wrap_count <= '0;
        end else if (ld_strobe) begin
            count      <= counter_input;
            reload     <= counter_input;
            wrap_count <= '0;
        end else if (reload_strobe) begin
            count <= reload;
            if (wrap_count != '1) begin
                wrap_count <= wrap_count + WRAP_WIDTH'(1);
            end
        end else if (dec_strobe) begin
            count <= count - COUNTER_WIDTH'(1);
        end
    end

    assign counter_output = count;

endmodule

// File: tb/tb_down_counter_timer_neg.sv
// Directed scoreboard bench for down_counter_timer_neg; wrap counter narrowed to 2 bits to reach saturation.
module tb_down_counter_timer_neg;

    localparam int CW = 64;
    localparam int WW = 2;

    logic          clock0 = 1'b1;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] counter_input = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          auto_reload = 1'b0;
    logic [CW-1:0] counter_output;
    logic          busy;
    logic          done;
    logic          tc_pulse;
    logic [WW-1:0] wrap_count;

    typedef struct {
        string         tag;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
        logic          tc;
        logic [WW-1:0] wrap;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   failures = 0;

    down_counter_timer_neg #(
        .COUNTER_WIDTH (CW),
        .WRAP_WIDTH    (WW)
    ) dut (
        .clock0         (clock0),
        .reset_n        (reset_n),
        .load           (load),
        .counter_input  (counter_input),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .auto_reload    (auto_reload),
        .counter_output (counter_output),
        .busy           (busy),
        .done           (done),
        .tc_pulse       (tc_pulse),
        .wrap_count     (wrap_count)
    );

    always #5 clock0 = ~clock0;

    task automatic compare(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        checks++;
        assert (scoreboard.size() != 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = scoreboard.pop_front();
        compare({e.tag, ".count"}, counter_output, e.cnt);
        compare({e.tag, ".busy"}, CW'(busy), CW'(e.busy));
        compare({e.tag, ".done"}, CW'(done), CW'(e.done));
        compare({e.tag, ".tc"}, CW'(tc_pulse), CW'(e.tc));
        compare({e.tag, ".wrap"}, CW'(wrap_count), CW'(e.wrap));
    endtask

    // Drive one edge's inputs, queue the expected outputs, sample just after the falling edge.
    task automatic apply_stimulus(
        input string         tag,
        input logic          rst_v,
        input logic          ld_v,
        input logic [CW-1:0] val_v,
        input logic          st_v,
        input logic          sp_v,
        input logic          ps_v,
        input logic          ar_v,
        input logic [CW-1:0] e_cnt,
        input logic          e_busy,
        input logic          e_done,
        input logic          e_tc,
        input logic [WW-1:0] e_wrap
    );
        exp_t e;
        @(posedge clock0);
        reset_n       = rst_v;
        load          = ld_v;
        counter_input = val_v;
        start         = st_v;
        stop          = sp_v;
        pause         = ps_v;
        auto_reload   = ar_v;
        e.tag  = tag;
        e.cnt  = e_cnt;
        e.busy = e_busy;
        e.done = e_done;
        e.tc   = e_tc;
        e.wrap = e_wrap;
        scoreboard.push_back(e);
        @(negedge clock0);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting down_counter_timer_neg bench");

        // Reset beats a simultaneous load.
        apply_stimulus("reset_load", 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load 3, start, count to zero.
        apply_stimulus("ld3",    1, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        apply_stimulus("st3",    1, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0);
        apply_stimulus("c3_2",   1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        apply_stimulus("c3_1",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        apply_stimulus("c3_0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        apply_stimulus("c3_dn",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Period-4 auto-reload for 16 edges; 2-bit wrap counter saturates at 3.
        apply_stimulus("ld4",    1, 1, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        apply_stimulus("st4",    1, 0, 0, 1, 0, 0, 1, 4, 1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            apply_stimulus($sformatf("ar_%0d", k), 1, 0, 0, 0, 0, 0, 1,
                           CW'((k % 4 == 0) ? 4 : 4 - (k % 4)), 1, 0, (k % 4 == 0),
                           WW'((k / 4 > 3) ? 3 : k / 4));
        end
        // Stop with start in the same cycle: IDLE, count and wrap held.
        apply_stimulus("stop_ar", 1, 0, 0, 1, 1, 0, 1, 4, 0, 0, 0, 3);

        // Pause holds the count; release spends one edge re-entering RUN.
        apply_stimulus("ld6",    1, 1, 6, 0, 0, 0, 0, 6, 0, 0, 0, 0);
        apply_stimulus("st6",    1, 0, 0, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        apply_stimulus("c6_5",   1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        apply_stimulus("c6_4",   1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus($sformatf("pause_%0d", k), 1, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0);
        end
        apply_stimulus("resume", 1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        apply_stimulus("c6_3",   1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        apply_stimulus("c6_2",   1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        apply_stimulus("c6_1",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        apply_stimulus("c6_0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        // Load zero with start goes straight to DONE with a pulse; start in DONE at zero pulses again.
        apply_stimulus("ld0st",  1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        apply_stimulus("z_dn",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus("z_rest", 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        apply_stimulus("z_dn2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Mid-run load beats stop; start while running is ignored; reset mid-run clears with no pulse.
        apply_stimulus("ld9st",  1, 1, 9, 1, 0, 0, 0, 9, 1, 0, 0, 0);
        apply_stimulus("c9_8",   1, 0, 0, 1, 0, 0, 0, 8, 1, 0, 0, 0);
        apply_stimulus("ld9sp",  1, 1, 9, 0, 1, 0, 0, 9, 0, 0, 0, 0);
        apply_stimulus("st9",    1, 0, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0);
        apply_stimulus("c9_8b",  1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        apply_stimulus("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus("post_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reload of 1: pulse every edge; dropping auto_reload finishes on the next terminal.
        apply_stimulus("ld1",    1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        apply_stimulus("st1",    1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        apply_stimulus("p1_a",   1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        apply_stimulus("p1_b",   1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 2);
        apply_stimulus("p1_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        apply_stimulus("p1_dn",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);

        checks++;
        assert (scoreboard.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", scoreboard.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
